ex_stage: RTL and testbench

- Execute stage that consumes the ID/EX pipeline register outputs and produces the ALU result, store data, branch/jump target and redirect for the EX/MEM register and the fetch PC mux.
- Applies forwarding selects from the hazard unit, resolves branches, and executes shifts on a serial multi-cycle shifter.
- While the shifter is busy it raises o_stall_e, which freezes PC, IF/ID and ID/EX and bubbles EX/MEM.

---
 rtl/ex_stage.sv | 175 +++++++++++++++++
 tb/tb_ex_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and a serial multi-cycle shifter.
// Define EX_FAST_SHIFT_EN to replace the serial shifter with a zero-latency barrel shifter.
module ex_stage #(
  parameter int unsigned XLEN                 = 32,
  parameter int unsigned SHIFT_BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush_e,
  input  logic [XLEN-1:0] i_regs_do1_e,
  input  logic [XLEN-1:0] i_regs_do2_e,
  input  logic [XLEN-1:0] i_imm32_e,
  input  logic [XLEN-1:0] i_pc_e,
  input  logic [6:0]      i_opcode_e,
  input  logic [2:0]      i_f3_e,
  input  logic [2:0]      i_alu_ctl_e,
  input  logic [1:0]      i_alu_shift_e,
  input  logic [1:0]      i_alu_src_opa_e,
  input  logic            i_alu_src_opb_e,
  input  logic            i_jmp_e,
  input  logic            i_branch_e,
  input  logic [1:0]      i_fwd_a_e,
  input  logic [1:0]      i_fwd_b_e,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [XLEN-1:0] i_result_w,
  output logic [XLEN-1:0] o_alu_result_e,
  output logic [XLEN-1:0] o_write_data_e,
  output logic [XLEN-1:0] o_pc_target_e,
  output logic            o_pc_src_e,
  output logic            o_stall_e
);

  localparam logic [6:0] OpJalr = 7'b1100111;

  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, shift_res;
  logic [4:0]      shamt;
  logic            is_shift, in_done, cond;

  function automatic logic [XLEN-1:0] shift_op(input logic [XLEN-1:0] v,
                                               input logic [1:0]      dir,
                                               input logic [4:0]      k);
    case (dir)
      2'b01:   shift_op = v >> k;
      2'b10:   shift_op = XLEN'($signed(v) >>> k);
      default: shift_op = v << k;
    endcase
  endfunction

  always_comb begin
    case (i_fwd_a_e)
      2'b01:   fwd_a = i_result_w;
      2'b10:   fwd_a = i_alu_result_m;
      default: fwd_a = i_regs_do1_e;
    endcase
    case (i_fwd_b_e)
      2'b01:   fwd_b = i_result_w;
      2'b10:   fwd_b = i_alu_result_m;
      default: fwd_b = i_regs_do2_e;
    endcase
    case (i_alu_src_opa_e)
      2'b00:   op_a = fwd_a;
      2'b01:   op_a = i_pc_e;
      default: op_a = '0;
    endcase
    op_b = i_alu_src_opb_e ? i_imm32_e : fwd_b;
  end

  assign shamt    = op_b[4:0];
  assign is_shift = (i_alu_ctl_e == 3'b111);

`ifdef EX_FAST_SHIFT_EN
  logic unused_fast;
  assign unused_fast = ^{i_clk, i_rst};
  assign shift_res   = shift_op(op_a, i_alu_shift_e, shamt);
  assign in_done     = 1'b0;
  assign o_stall_e   = 1'b0;
`else
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [4:0] Step    = 5'(SHIFT_BITS_PER_CYCLE);

  logic [1:0]      state_q, state_d, dir_q, dir_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [4:0]      cnt_q, cnt_d, first_amt, step_amt;
  logic            stall_raw;

  assign first_amt = (shamt < Step) ? shamt : Step;
  assign step_amt  = (cnt_q < Step) ? cnt_q : Step;

  // The capture cycle already performs the first step, so an N-bit shift stalls N cycles.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    stall_raw = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_shift && (shamt != 5'd0) && !i_flush_e) begin
          stall_raw = 1'b1;
          sh_d      = shift_op(op_a, i_alu_shift_e, first_amt);
          cnt_d     = shamt - first_amt;
          dir_d     = i_alu_shift_e;
          state_d   = (shamt == first_amt) ? StDone : StShift;
        end
      end
      StShift: begin
        stall_raw = 1'b1;
        sh_d      = shift_op(sh_q, dir_q, step_amt);
        cnt_d     = cnt_q - step_amt;
        if (cnt_q == step_amt) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (i_flush_e) begin
      state_d   = StIdle;
      stall_raw = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign o_stall_e = stall_raw & ~i_rst;
  assign in_done   = (state_q == StDone);
  // Only a zero-amount shift issued from IDLE exposes this path.
  assign shift_res = op_a;
`endif

  always_comb begin
    case (i_alu_ctl_e)
      3'b000:  o_alu_result_e = op_a + op_b;
      3'b001:  o_alu_result_e = op_a - op_b;
      3'b010:  o_alu_result_e = op_a & op_b;
      3'b011:  o_alu_result_e = op_a | op_b;
      3'b100:  o_alu_result_e = op_a ^ op_b;
      3'b101:  o_alu_result_e = XLEN'($signed(op_a) < $signed(op_b));
      3'b110:  o_alu_result_e = XLEN'(op_a < op_b);
      default: o_alu_result_e = shift_res;
    endcase
`ifndef EX_FAST_SHIFT_EN
    if (in_done) o_alu_result_e = sh_q;
`endif
  end

  always_comb begin
    case (i_f3_e)
      3'b000:  cond = (fwd_a == fwd_b);
      3'b001:  cond = (fwd_a != fwd_b);
      3'b100:  cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  cond = (fwd_a < fwd_b);
      3'b111:  cond = (fwd_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign o_pc_target_e  = (i_opcode_e == OpJalr) ? ((fwd_a + i_imm32_e) & ~XLEN'(1))
                                                 : (i_pc_e + i_imm32_e);
  assign o_pc_src_e     = (i_jmp_e | (i_branch_e & cond)) & ~o_stall_e;
  assign o_write_data_e = fwd_b;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with the default serial shifter.
module tb_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush_e;
  logic [31:0] i_regs_do1_e, i_regs_do2_e, i_imm32_e, i_pc_e;
  logic [6:0]  i_opcode_e;
  logic [2:0]  i_f3_e, i_alu_ctl_e;
  logic [1:0]  i_alu_shift_e, i_alu_src_opa_e, i_fwd_a_e, i_fwd_b_e;
  logic        i_alu_src_opb_e, i_jmp_e, i_branch_e;
  logic [31:0] i_alu_result_m, i_result_w;
  logic [31:0] o_alu_result_e, o_write_data_e, o_pc_target_e;
  logic        o_pc_src_e, o_stall_e;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  ex_stage #(.XLEN(32), .SHIFT_BITS_PER_CYCLE(1)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_flush_e       (i_flush_e),
    .i_regs_do1_e    (i_regs_do1_e),
    .i_regs_do2_e    (i_regs_do2_e),
    .i_imm32_e       (i_imm32_e),
    .i_pc_e          (i_pc_e),
    .i_opcode_e      (i_opcode_e),
    .i_f3_e          (i_f3_e),
    .i_alu_ctl_e     (i_alu_ctl_e),
    .i_alu_shift_e   (i_alu_shift_e),
    .i_alu_src_opa_e (i_alu_src_opa_e),
    .i_alu_src_opb_e (i_alu_src_opb_e),
    .i_jmp_e         (i_jmp_e),
    .i_branch_e      (i_branch_e),
    .i_fwd_a_e       (i_fwd_a_e),
    .i_fwd_b_e       (i_fwd_b_e),
    .i_alu_result_m  (i_alu_result_m),
    .i_result_w      (i_result_w),
    .o_alu_result_e  (o_alu_result_e),
    .o_write_data_e  (o_write_data_e),
    .o_pc_target_e   (o_pc_target_e),
    .o_pc_src_e      (o_pc_src_e),
    .o_stall_e       (o_stall_e)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    i_flush_e = 0; i_regs_do1_e = 0; i_regs_do2_e = 0; i_imm32_e = 0; i_pc_e = 0;
    i_opcode_e = 0; i_f3_e = 0; i_alu_ctl_e = 0; i_alu_shift_e = 0; i_alu_src_opa_e = 0;
    i_alu_src_opb_e = 0; i_jmp_e = 0; i_branch_e = 0; i_fwd_a_e = 0; i_fwd_b_e = 0;
    i_alu_result_m = 0; i_result_w = 0;
  endtask

  task automatic set_shift(input logic [1:0] dir, input logic [31:0] a, input logic [31:0] amt);
    clr();
    i_alu_ctl_e = 3'b111; i_alu_shift_e = dir; i_regs_do1_e = a;
    i_alu_src_opb_e = 1'b1; i_imm32_e = amt;
  endtask

  initial begin
    // Reset with zeroed ID/EX, then with a shift presented
    clr(); i_rst = 1'b1;
    tick(); #1;
    chk("rst_result", o_alu_result_e, 32'h0);
    chk("rst_target", o_pc_target_e, 32'h0);
    chk("rst_pc_src", {31'h0, o_pc_src_e}, 32'h0);
    chk("rst_stall", {31'h0, o_stall_e}, 32'h0);
    set_shift(2'b00, 32'h1, 32'd3); #1;
    chk("rst_shift_stall0", {31'h0, o_stall_e}, 32'h0);
    tick(); #1;
    chk("rst_shift_stall1", {31'h0, o_stall_e}, 32'h0);
    i_rst = 1'b0; #1;
    chk("post_rst_start", {31'h0, o_stall_e}, 32'h1);
    tick(); chk("post_rst_s1", {31'h0, o_stall_e}, 32'h1);
    tick(); chk("post_rst_s2", {31'h0, o_stall_e}, 32'h1);
    tick();
    chk("post_rst_done_stall", {31'h0, o_stall_e}, 32'h0);
    chk("post_rst_done_res", o_alu_result_e, 32'h8);

    // Combinational ALU ops
    tick(); clr();
    i_regs_do1_e = 32'hFFFF_FFFF; i_alu_src_opb_e = 1'b1; i_imm32_e = 32'h1; #1;
    chk("add_wrap", o_alu_result_e, 32'h0);
    i_regs_do1_e = 32'd5; i_imm32_e = 32'd7; i_alu_ctl_e = 3'b001; #1;
    chk("sub_5_7", o_alu_result_e, 32'hFFFF_FFFE);
    i_alu_ctl_e = 3'b101; #1;
    chk("slt_5_7", o_alu_result_e, 32'h1);
    i_regs_do1_e = 32'hFFFF_FFFF; i_imm32_e = 32'h1; i_alu_ctl_e = 3'b110; #1;
    chk("sltu_max_1", o_alu_result_e, 32'h0);
    i_alu_ctl_e = 3'b101; #1;
    chk("slt_m1_1", o_alu_result_e, 32'h1);
    i_regs_do1_e = 32'hF0F0_00FF; i_imm32_e = 32'h0FF0_0F0F; i_alu_ctl_e = 3'b100; #1;
    chk("xor", o_alu_result_e, 32'hFF00_0FF0);

    // sra by 4 with a jump present: redirect must be held off while stalled
    set_shift(2'b10, 32'h8000_0000, 32'd4); i_jmp_e = 1'b1; #1;
    chk("sra_stall0", {31'h0, o_stall_e}, 32'h1);
    chk("sra_pc_src_gated", {31'h0, o_pc_src_e}, 32'h0);
    tick(); chk("sra_stall1", {31'h0, o_stall_e}, 32'h1);
    tick(); chk("sra_stall2", {31'h0, o_stall_e}, 32'h1);
    tick(); chk("sra_stall3", {31'h0, o_stall_e}, 32'h1);
    tick();
    chk("sra_done_stall", {31'h0, o_stall_e}, 32'h0);
    chk("sra_done_res", o_alu_result_e, 32'hF800_0000);
    chk("sra_done_pc_src", {31'h0, o_pc_src_e}, 32'h1);

    tick(); set_shift(2'b01, 32'h8000_0000, 32'd4); #1;
    chk("srl_stall0", {31'h0, o_stall_e}, 32'h1);
    tick(); tick(); tick();
    chk("srl_stall3", {31'h0, o_stall_e}, 32'h1);
    tick();
    chk("srl_done_res", o_alu_result_e, 32'h0800_0000);
    chk("srl_done_stall", {31'h0, o_stall_e}, 32'h0);

    tick(); set_shift(2'b00, 32'h8000_0000, 32'd0); #1;
    chk("sll0_res", o_alu_result_e, 32'h8000_0000);
    chk("sll0_stall", {31'h0, o_stall_e}, 32'h0);
    tick();
    chk("sll0_stay_idle", {31'h0, o_stall_e}, 32'h0);

    // Captured operand survives a change of the forwarded source
    set_shift(2'b00, 32'h55, 32'd1); i_fwd_a_e = 2'b10; i_alu_result_m = 32'h3; #1;
    chk("fwd_shift_stall", {31'h0, o_stall_e}, 32'h1);
    tick(); i_alu_result_m = 32'hDEAD_0000; #1;
    chk("fwd_shift_res", o_alu_result_e, 32'h6);

    tick(); clr();
    i_regs_do2_e = 32'h1; i_result_w = 32'hCAFE_F00D; i_alu_result_m = 32'h1234;
    i_fwd_b_e = 2'b01; #1; chk("wdata_w", o_write_data_e, 32'hCAFE_F00D);
    i_fwd_b_e = 2'b10; #1; chk("wdata_m", o_write_data_e, 32'h1234);
    i_fwd_b_e = 2'b11; #1; chk("wdata_11", o_write_data_e, 32'h1);
    i_fwd_a_e = 2'b01; i_alu_src_opb_e = 1'b1; i_imm32_e = 32'h3; #1;
    chk("add_fwd_w", o_alu_result_e, 32'hCAFE_F010);
    i_alu_src_opa_e = 2'b01; i_pc_e = 32'h200; i_imm32_e = 32'h4; #1;
    chk("add_pc", o_alu_result_e, 32'h204);

    // Flush in the second SHIFT cycle of a 10-bit shift
    set_shift(2'b00, 32'h1, 32'd10); #1;
    chk("flush_stall0", {31'h0, o_stall_e}, 32'h1);
    tick(); chk("flush_stall1", {31'h0, o_stall_e}, 32'h1);
    tick(); i_flush_e = 1'b1; #1;
    chk("flush_stall_drop", {31'h0, o_stall_e}, 32'h0);
    tick(); i_flush_e = 1'b0; i_alu_ctl_e = 3'b000; #1;
    chk("flush_idle_res", o_alu_result_e, 32'd11);
    chk("flush_idle_stall", {31'h0, o_stall_e}, 32'h0);

    // Shift arriving with a flush does not start
    i_alu_ctl_e = 3'b111; i_flush_e = 1'b1; #1;
    chk("flush_nostart", {31'h0, o_stall_e}, 32'h0);
    tick(); i_flush_e = 1'b0; i_alu_ctl_e = 3'b000; #1;
    chk("flush_nostart_idle", {31'h0, o_stall_e}, 32'h0);

    // Branches and jumps
    tick(); clr();
    i_regs_do1_e = 32'h10; i_regs_do2_e = 32'h10; i_pc_e = 32'h100; i_imm32_e = 32'h20;
    i_branch_e = 1'b1; i_f3_e = 3'b000; #1;
    chk("beq_taken", {31'h0, o_pc_src_e}, 32'h1);
    chk("beq_target", o_pc_target_e, 32'h120);
    i_f3_e = 3'b001; #1;
    chk("bne_eq", {31'h0, o_pc_src_e}, 32'h0);
    i_regs_do1_e = 32'hFFFF_FFFF; i_regs_do2_e = 32'h1; i_f3_e = 3'b110; #1;
    chk("bltu_nt", {31'h0, o_pc_src_e}, 32'h0);
    i_f3_e = 3'b100; #1;
    chk("blt_taken", {31'h0, o_pc_src_e}, 32'h1);
    i_f3_e = 3'b010; #1;
    chk("f3_010_nt", {31'h0, o_pc_src_e}, 32'h0);
    clr();
    i_opcode_e = 7'b1100111; i_regs_do1_e = 32'h1001; i_imm32_e = 32'h2; i_pc_e = 32'h400;
    i_jmp_e = 1'b1; #1;
    chk("jalr_target", o_pc_target_e, 32'h1002);
    chk("jalr_pc_src", {31'h0, o_pc_src_e}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
